// File: rtl/bomb_timer.sv
// -----------------------------------------------------------------------------
// bomb_timer
//
// Game-logic stage feeding the VGA renderer. Each player owns one bomb slot
// that walks IDLE -> FRESH -> ARMED -> EXPLODE -> IDLE. Exploding bombs cover
// a cross-shaped area on the 10x10 grid; the per-cell code map and the
// player-hit flags are registered from the slot state.
//
// Ports
//   pixel_clk          clock
//   rst_n              asynchronous active-low reset
//   p1_place/p2_place  one-cycle placement requests
//   p1_x,p1_y,p2_x,p2_y  player grid positions (valid 0..9)
//   wall_map           1 = wall at cell y*10+x
//   p1_ack/p2_ack      one-cycle pulse when a placement is accepted
//   bomb_map           2-bit code per cell at [2*(y*10+x)+:2]
//                      (0 none, 1 fresh, 2 armed, 3 exploding)
//   p1_hit/p2_hit      player's cell lies inside an active blast
//
// Build option
//   BOMB_WALL_BLOCK_EN  when defined, each blast arm stops before the first
//                       wall cell in its direction; otherwise walls only
//                       affect placement legality.
// -----------------------------------------------------------------------------
module bomb_timer #(
  parameter int TICKS_PER_SEC = 25000000,
  parameter int BLAST_R       = 2
) (
  input  logic         pixel_clk,
  input  logic         rst_n,
  input  logic         p1_place,
  input  logic [3:0]   p1_x,
  input  logic [3:0]   p1_y,
  input  logic         p2_place,
  input  logic [3:0]   p2_x,
  input  logic [3:0]   p2_y,
  input  logic [99:0]  wall_map,
  output logic         p1_ack,
  output logic         p2_ack,
  output logic [199:0] bomb_map,
  output logic         p1_hit,
  output logic         p2_hit
);

  localparam int CW   = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int HALF = (TICKS_PER_SEC / 2 > 0) ? TICKS_PER_SEC / 2 : 1;
  localparam logic [CW-1:0] FULL_LAST = CW'(TICKS_PER_SEC - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

  // State encoding doubles as the bomb_map code of a non-exploding bomb.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FRESH   = 2'd1,
    S_ARMED   = 2'd2,
    S_EXPLODE = 2'd3
  } slot_state_e;

  function automatic logic [6:0] cell_idx(input logic [3:0] x, input logic [3:0] y);
    return ({3'd0, y} * 7'd10) + {3'd0, x};
  endfunction

  function automatic logic in_grid(input logic [3:0] x, input logic [3:0] y);
    return (x <= 4'd9) && (y <= 4'd9);
  endfunction

  // Legal request: own slot idle, on-grid, not a wall, not on the other bomb.
  function automatic logic place_ok(input logic        req,
                                    input slot_state_e own,
                                    input logic [3:0]  px,
                                    input logic [3:0]  py,
                                    input slot_state_e oth,
                                    input logic [3:0]  ox,
                                    input logic [3:0]  oy,
                                    input logic [99:0] walls);
    logic occupied;
    occupied = (oth != S_IDLE) && (ox == px) && (oy == py);
    return req && (own == S_IDLE) && in_grid(px, py) &&
           !walls[cell_idx(px, py)] && !occupied;
  endfunction

  slot_state_e   state_q [2];
  slot_state_e   state_d [2];
  logic [3:0]    x_q     [2];
  logic [3:0]    x_d     [2];
  logic [3:0]    y_q     [2];
  logic [3:0]    y_d     [2];
  logic [CW-1:0] cnt_q   [2];
  logic [CW-1:0] cnt_d   [2];

  logic [1:0]    ack_q, ack_d;
  logic [1:0]    hit_q, hit_d;
  logic [199:0]  bomb_map_q, bomb_map_d;

  logic [3:0]    req_x_s [2];
  logic [3:0]    req_y_s [2];
  logic [1:0]    acc_s;
  logic [1:0]    chain_s;
  logic [99:0]   blast_s [2];
  logic [99:0]   any_blast_s;
  logic [6:0]    slot_idx_s [2];
  logic          open_s;
  logic [4:0]    cx_s, cy_s;

  // Cross-shaped blast mask of each exploding slot, walking each arm outward.
  always_comb begin
    open_s = 1'b0;
    cx_s   = 5'd0;
    cy_s   = 5'd0;
    for (int s = 0; s < 2; s++) begin
      slot_idx_s[s] = cell_idx(x_q[s], y_q[s]);
      blast_s[s]    = '0;
      if (state_q[s] == S_EXPLODE) begin
        blast_s[s][slot_idx_s[s]] = 1'b1;
        for (int dir = 0; dir < 4; dir++) begin
          open_s = 1'b1;
          cx_s   = {1'b0, x_q[s]};
          cy_s   = {1'b0, y_q[s]};
          for (int d = 1; d <= BLAST_R; d++) begin
            // Stepping left/up from 0 wraps to 31.., which is off-grid.
            case (dir[1:0])
              2'd0:    cx_s = cx_s + 5'd1;
              2'd1:    cx_s = cx_s - 5'd1;
              2'd2:    cy_s = cy_s + 5'd1;
              2'd3:    cy_s = cy_s - 5'd1;
              default: cx_s = cx_s;
            endcase
            // Once an arm leaves the grid it stays closed: no wrap-around.
            open_s = open_s && (cx_s <= 5'd9) && (cy_s <= 5'd9);
`ifdef BOMB_WALL_BLOCK_EN
            open_s = open_s && !wall_map[cell_idx(cx_s[3:0], cy_s[3:0])];
`endif
            // A closed arm rewrites the (already set) bomb cell instead.
            blast_s[s][open_s ? cell_idx(cx_s[3:0], cy_s[3:0]) : slot_idx_s[s]] = 1'b1;
          end
        end
      end else begin
        blast_s[s] = '0;
      end
    end
    any_blast_s = blast_s[0] | blast_s[1];
  end

  // Request acceptance with p1 winning a same-cell tie; chain detection.
  always_comb begin
    req_x_s[0] = p1_x;
    req_y_s[0] = p1_y;
    req_x_s[1] = p2_x;
    req_y_s[1] = p2_y;
    acc_s[0] = place_ok(p1_place, state_q[0], p1_x, p1_y,
                        state_q[1], x_q[1], y_q[1], wall_map);
    acc_s[1] = place_ok(p2_place, state_q[1], p2_x, p2_y,
                        state_q[0], x_q[0], y_q[0], wall_map) &&
               !(acc_s[0] && (p1_x == p2_x) && (p1_y == p2_y));
    chain_s[0] = blast_s[1][slot_idx_s[0]];
    chain_s[1] = blast_s[0][slot_idx_s[1]];
  end

  // Per-slot life-cycle next state and counter.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      state_d[s] = state_q[s];
      cnt_d[s]   = cnt_q[s];
      x_d[s]     = x_q[s];
      y_d[s]     = y_q[s];
      case (state_q[s])
        S_IDLE: begin
          if (acc_s[s]) begin
            state_d[s] = S_FRESH;
            cnt_d[s]   = '0;
            x_d[s]     = req_x_s[s];
            y_d[s]     = req_y_s[s];
          end else begin
            state_d[s] = S_IDLE;
          end
        end
        S_FRESH, S_ARMED: begin
          if (chain_s[s]) begin
            state_d[s] = S_EXPLODE;
            cnt_d[s]   = '0;
          end else if (cnt_q[s] == FULL_LAST) begin
            state_d[s] = (state_q[s] == S_FRESH) ? S_ARMED : S_EXPLODE;
            cnt_d[s]   = '0;
          end else begin
            cnt_d[s] = cnt_q[s] + CW'(1'b1);
          end
        end
        S_EXPLODE: begin
          if (cnt_q[s] == HALF_LAST) begin
            state_d[s] = S_IDLE;
            cnt_d[s]   = '0;
          end else begin
            cnt_d[s] = cnt_q[s] + CW'(1'b1);
          end
        end
        default: begin
          state_d[s] = S_IDLE;
          cnt_d[s]   = '0;
        end
      endcase
    end
  end

  // Output image: blast has priority over a resting bomb's own code.
  always_comb begin
    bomb_map_d = '0;
    for (int c = 0; c < 100; c++) begin
      if (any_blast_s[c]) begin
        bomb_map_d[2*c +: 2] = 2'd3;
      end else if ((state_q[0] != S_IDLE) && (slot_idx_s[0] == 7'(c))) begin
        bomb_map_d[2*c +: 2] = state_q[0];
      end else if ((state_q[1] != S_IDLE) && (slot_idx_s[1] == 7'(c))) begin
        bomb_map_d[2*c +: 2] = state_q[1];
      end else begin
        bomb_map_d[2*c +: 2] = 2'd0;
      end
    end
    hit_d[0] = in_grid(p1_x, p1_y) && any_blast_s[cell_idx(p1_x, p1_y)];
    hit_d[1] = in_grid(p2_x, p2_y) && any_blast_s[cell_idx(p2_x, p2_y)];
    ack_d    = acc_s;
  end

  // Slot state and registered outputs.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < 2; s++) begin
        state_q[s] <= S_IDLE;
        cnt_q[s]   <= '0;
        x_q[s]     <= 4'd0;
        y_q[s]     <= 4'd0;
      end
      ack_q      <= 2'b00;
      hit_q      <= 2'b00;
      bomb_map_q <= '0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        state_q[s] <= state_d[s];
        cnt_q[s]   <= cnt_d[s];
        x_q[s]     <= x_d[s];
        y_q[s]     <= y_d[s];
      end
      ack_q      <= ack_d;
      hit_q      <= hit_d;
      bomb_map_q <= bomb_map_d;
    end
  end

  assign p1_ack   = ack_q[0];
  assign p2_ack   = ack_q[1];
  assign p1_hit   = hit_q[0];
  assign p2_hit   = hit_q[1];
  assign bomb_map = bomb_map_q;

endmodule
